imm_encoder: RTL and testbench

- Inverse of the core's immediate sign-extension path: takes a 32-bit extended immediate plus a 5-bit opcode (instr[6:2]) and scatters it back into the RV32I instruction bit positions.
- Checks that the immediate is representable in the target format.
- Used by the loop detector / branch-predictor refill path and by trace/self-test generators to rebuild instruction words.
- Valid/ready in, valid/ready out, with a 2-entry output buffer so full throughput survives downstream stalls.

---
 rtl/imm_pkg.sv | 30 +++
 rtl/imm_field_pack.sv | 54 +++++
 rtl/imm_encoder.sv | 99 +++++++++
 tb/tb_imm_encoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared opcode constants, buffer entry type and range-check helpers for the
// RV32I immediate encoder (and the core's sign extender).
package imm_pkg;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_entry_t;

  // True when v[31:bits-1] are all equal, i.e. v is a sign-extended bits-wide value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

  function automatic logic fits_unsigned(input logic [31:0] v, input int unsigned bits);
    return (v >> bits) == '0;
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational scatter of a 32-bit extended immediate into RV32I instruction
// bit positions, plus the representability check for the target format.
module imm_field_pack
  import imm_pkg::*;
(
  input  logic [31:0] imm_in,
  input  logic [4:0]  op_code,
  input  logic        enc_en,
  input  logic        enc_unsigned,
  output logic [31:0] instr_o,
  output logic        err_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    instr_o = {25'd0, op_code, 2'b11};
    err_o   = 1'b0;
    if (enc_en) begin
      unique case (op_code)
        OPC_LUI, OPC_AUIPC: begin
          instr_o[31:12] = imm_in[31:12];
          err_o          = |imm_in[11:0];
        end
        OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
          instr_o[31:20] = imm_in[11:0];
          err_o          = enc_unsigned ? !fits_unsigned(imm_in, 12) : !fits_signed(imm_in, 12);
        end
        OPC_STORE: begin
          instr_o[31:25] = imm_in[11:5];
          instr_o[11:7]  = imm_in[4:0];
          err_o          = enc_unsigned ? !fits_unsigned(imm_in, 12) : !fits_signed(imm_in, 12);
        end
        OPC_BRANCH: begin
          instr_o[31]    = imm_in[12];
          instr_o[30:25] = imm_in[10:5];
          instr_o[11:8]  = imm_in[4:1];
          instr_o[7]     = imm_in[11];
          err_o          = imm_in[0] |
                           (enc_unsigned ? !fits_unsigned(imm_in, 13) : !fits_signed(imm_in, 13));
        end
        OPC_JAL: begin
          // JAL offsets are always signed; enc_unsigned has no meaning here.
          instr_o[31]    = imm_in[20];
          instr_o[30:21] = imm_in[10:1];
          instr_o[20]    = imm_in[11];
          instr_o[19:12] = imm_in[19:12];
          err_o          = imm_in[0] | !fits_signed(imm_in, 21);
        end
        default: err_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder with valid/ready handshake and a DEPTH-entry output FIFO.
// Optional error counter port enabled by defining IMM_ENCODER_ERR_CNT_EN.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] imm_in,
  input  logic [4:0]  op_code,
  input  logic        enc_en,
  input  logic        enc_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_out,
  output logic        range_err
`ifdef IMM_ENCODER_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  enc_entry_t       mem_q [DEPTH];
  enc_entry_t       enc;
  logic [31:0]      enc_instr;
  logic             enc_err;
  logic             push, pop;

  imm_field_pack u_pack (
    .imm_in       (imm_in),
    .op_code      (op_code),
    .enc_en       (enc_en),
    .enc_unsigned (enc_unsigned),
    .instr_o      (enc_instr),
    .err_o        (enc_err)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    enc       = '{instr: enc_instr, err: enc_err};
    in_ready  = (count_q != CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    instr_out = out_valid ? mem_q[rd_ptr_q].instr : '0;
    range_err = out_valid ? mem_q[rd_ptr_q].err   : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; outputs are masked by out_valid when empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc;
  end

`ifdef IMM_ENCODER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, backpressure, reset
// and randomized traffic compared against a queue-based reference model.
module tb_imm_encoder;
  import imm_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] imm_in;
  logic [4:0]  op_code;
  logic        enc_en, enc_unsigned;
  logic        out_valid, out_ready;
  logic [31:0] instr_out;
  logic        range_err;
`ifdef IMM_ENCODER_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int tests = 0;
  int fails = 0;
  enc_entry_t exp_q[$];
  int unsigned exp_err_cnt = 0;

  imm_encoder #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imm_in       (imm_in),
    .op_code      (op_code),
    .enc_en       (enc_en),
    .enc_unsigned (enc_unsigned),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .instr_out    (instr_out),
    .range_err    (range_err)
`ifdef IMM_ENCODER_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder: field placement by shifts/masks, ranges by integer bounds.
  function automatic enc_entry_t ref_enc(input logic [31:0] imm, input logic [4:0] op,
                                         input logic en, input logic uns);
    enc_entry_t r;
    int s;
    s = $signed(imm);
    r.instr = {25'd0, op, 2'b11};
    r.err   = 1'b0;
    if (en) begin
      case (op)
        5'b01101, 5'b00101: begin
          r.instr |= imm & 32'hFFFF_F000;
          r.err = (imm % 4096) != 0;
        end
        5'b00100, 5'b00000, 5'b11001: begin
          r.instr |= (imm & 32'hFFF) << 20;
          r.err = uns ? (imm >= 32'd4096) : (s < -2048 || s > 2047);
        end
        5'b01000: begin
          r.instr |= (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
          r.err = uns ? (imm >= 32'd4096) : (s < -2048 || s > 2047);
        end
        5'b11000: begin
          r.instr |= (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                     (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
          r.err = (imm % 2 == 1) || (uns ? (imm >= 32'd8192) : (s < -4096 || s > 4095));
        end
        5'b11011: begin
          r.instr |= (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                     (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
          r.err = (imm % 2 == 1) || s < -(1 << 20) || s > (1 << 20) - 1;
        end
        default: r.err = 1'b1;
      endcase
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    enc_entry_t head;
    head = (exp_q.size() != 0) ? exp_q[0] : '{instr: 32'd0, err: 1'b0};
    check({tag, ".in_ready"},  32'(in_ready),  32'(exp_q.size() < DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    check({tag, ".instr_out"}, instr_out, head.instr);
    check({tag, ".range_err"}, 32'(range_err), 32'(head.err));
`ifdef IMM_ENCODER_ERR_CNT_EN
    check({tag, ".err_count"}, 32'(err_count), exp_err_cnt);
`endif
  endtask

  // Called at a falling edge: drive, check current outputs, clock, update model.
  task automatic step(input string tag, input logic v, input logic [31:0] imm,
                      input logic [4:0] op, input logic en, input logic uns,
                      input logic ordy);
    bit acc, pop;
    enc_entry_t e;
    in_valid = v; imm_in = imm; op_code = op; enc_en = en; enc_unsigned = uns;
    out_ready = ordy;
    check_outputs(tag);
    acc = v && exp_q.size() < DEPTH;
    pop = ordy && exp_q.size() != 0;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      e = ref_enc(imm, op, en, uns);
      exp_q.push_back(e);
      if (e.err && exp_err_cnt != 32'hFFFF) exp_err_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 1'b0, $urandom, 5'($urandom), 1'b1, 1'b0, ordy);
  endtask

  logic [4:0] ops [9] = '{5'b01101, 5'b00101, 5'b00100, 5'b00000, 5'b11001,
                          5'b01000, 5'b11000, 5'b11011, 5'b11111};

  initial begin
    logic [31:0] rimm;
    rst = 1'b1;
    in_valid = 1'b0; imm_in = '0; op_code = '0; enc_en = 1'b0; enc_unsigned = 1'b0;
    out_ready = 1'b0;
    #3;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.instr_out", instr_out, 32'd0);
    check("reset.range_err", 32'(range_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed encodings, each popped the following cycle.
    step("i_neg", 1'b1, 32'hFFFF_F800, 5'b00100, 1'b1, 1'b0, 1'b1);
    check("i_neg_const", instr_out, 32'h8000_0013);
    step("i_pos_over", 1'b1, 32'h0000_0800, 5'b00100, 1'b1, 1'b0, 1'b1);
    check("i_pos_over_err", 32'(range_err), 32'd1);
    step("i_uns_ok", 1'b1, 32'h0000_0FFF, 5'b00000, 1'b1, 1'b1, 1'b1);
    step("b_neg", 1'b1, 32'hFFFF_FFFC, 5'b11000, 1'b1, 1'b0, 1'b1);
    check("b_neg_const", instr_out, 32'hFE00_0EE3);
    step("b_odd", 1'b1, 32'h0000_0003, 5'b11000, 1'b1, 1'b0, 1'b1);
    check("b_odd_err", 32'(range_err), 32'd1);
    step("b_uns_edge", 1'b1, 32'h0000_1FFE, 5'b11000, 1'b1, 1'b1, 1'b1);
    step("lui", 1'b1, 32'h1234_5000, 5'b01101, 1'b1, 1'b0, 1'b1);
    check("lui_const", instr_out, 32'h1234_5037);
    step("auipc_low", 1'b1, 32'h1234_5001, 5'b00101, 1'b1, 1'b0, 1'b1);
    step("jal", 1'b1, 32'h0000_0800, 5'b11011, 1'b1, 1'b0, 1'b1);
    check("jal_const", instr_out, 32'h0010_006F);
    check("jal_err", 32'(range_err), 32'd0);
    step("jal_over", 1'b1, 32'h0010_0000, 5'b11011, 1'b1, 1'b1, 1'b1);
    step("store", 1'b1, 32'hFFFF_F805, 5'b01000, 1'b1, 1'b0, 1'b1);
    step("dis", 1'b1, 32'h0000_0003, 5'b11000, 1'b0, 1'b0, 1'b1);
    check("dis_const", instr_out, 32'h0000_0063);
    step("illegal", 1'b1, 32'h0000_0000, 5'b11111, 1'b1, 1'b0, 1'b1);
    check("illegal_err", 32'(range_err), 32'd1);
    idle("drain", 1'b1);

    // Backpressure: third request waits, then push and pop share a cycle.
    step("bp1", 1'b1, 32'h0000_0010, 5'b00100, 1'b1, 1'b0, 1'b0);
    step("bp2", 1'b1, 32'h0000_0020, 5'b00100, 1'b1, 1'b0, 1'b0);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    step("bp3_blocked", 1'b1, 32'h0000_0030, 5'b00100, 1'b1, 1'b0, 1'b0);
    step("bp3_pop_only", 1'b1, 32'h0000_0030, 5'b00100, 1'b1, 1'b0, 1'b1);
    step("bp3_push_pop", 1'b1, 32'h0000_0030, 5'b00100, 1'b1, 1'b0, 1'b1);
    step("bp_after", 1'b1, 32'h0000_0040, 5'b00100, 1'b1, 1'b0, 1'b1);
    idle("bp_drain1", 1'b1);
    idle("bp_drain2", 1'b1);

    // Randomized traffic with boundary-heavy immediates.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rimm = $urandom;
        1: rimm = 32'($urandom_range(0, 16383)) - 32'd8192;
        2: rimm = 32'($urandom_range(0, 4_194_303)) - 32'd2_097_152;
        default: rimm = {$urandom_range(0, 1) ? 20'hFFFFF : 20'h00000, 12'($urandom)};
      endcase
      step("rnd", 1'($urandom_range(0, 3) != 0), rimm, ops[$urandom_range(0, 8)],
           1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    idle("rnd_drain1", 1'b1);
    idle("rnd_drain2", 1'b1);

    // Asynchronous reset with two entries buffered.
    step("rst_fill1", 1'b1, 32'h0000_0100, 5'b00100, 1'b1, 1'b0, 1'b0);
    step("rst_fill2", 1'b1, 32'h0000_0200, 5'b00100, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.instr_out", instr_out, 32'd0);
    check("rst_mid.range_err", 32'(range_err), 32'd0);
    exp_q.delete();
    exp_err_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rel.in_ready", 32'(in_ready), 32'd1);
    check("rst_rel.out_valid", 32'(out_valid), 32'd0);
    step("rst_push", 1'b1, 32'h0000_0300, 5'b00100, 1'b1, 1'b0, 1'b0);
    idle("rst_head", 1'b1);
    idle("rst_empty", 1'b1);
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
